if_fetch_unit: RTL and testbench

Instruction-fetch stage feeding the decode stage of the five-stage pipeline. Holds the architectural fetch PC, issues one-outstanding-at-a-time requests to instruction memory over a req/ack handshake, and buffers returned words in a small queue. Decode consumes words through a valid/ready handshake and drives a redirect (`pc_src`/`new_pc`) back into this block on taken branches and jumps.

---
 rtl/if_pkg.sv | 18 +
 rtl/fetch_queue.sv | 60 ++++++
 rtl/if_fetch_unit.sv | 132 +++++++++++++
 tb/tb_if_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam int unsigned ENTRY_W = 64;
    localparam logic [31:0] PC_INCR = 32'd4;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {instr, pc} entries with flush; pointers wrap modulo DEPTH.
module fetch_queue
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [ENTRY_W-1:0]             push_data,
    input  logic                           pop,
    input  logic                           flush,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH):0]         count,
    output logic [ENTRY_W-1:0]             head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

    // Pointer and occupancy bookkeeping; flush overrides push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only observed while non-empty, so no reset.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: fetch PC, single-outstanding imem requests, fetch queue.
// Optional macro FETCH_BYPASS_EN: forwards an acked word straight to decode when the queue is empty.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        pc_src,
    input  logic [31:0] new_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t       state, state_next;
    logic [31:0]        fetch_pc, fetch_pc_next;
    logic [31:0]        drop_addr, drop_addr_next;

    logic               q_push, q_pop, q_flush;
    logic               q_full, q_empty;
    logic [CW-1:0]      q_count, count_after;
    logic [ENTRY_W-1:0] q_head;
    logic               bypass_hit;
    logic [31:0]        head_instr, head_pc;

    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .push_data ({imem_rdata, fetch_pc}),
        .pop       (q_pop),
        .flush     (q_flush),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count),
        .head      (q_head)
    );

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = (state == REQ) && imem_ack && q_empty && !pc_src;
`else
    assign bypass_hit = 1'b0;
`endif

    // State, fetch PC and in-flight drop address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            drop_addr <= RESET_PC;
        end else begin
            state     <= state_next;
            fetch_pc  <= fetch_pc_next;
            drop_addr <= drop_addr_next;
        end
    end

    // Next-state, PC update and queue control; a redirect flushes and blocks pop/push.
    always_comb begin
        state_next     = state;
        fetch_pc_next  = fetch_pc;
        drop_addr_next = drop_addr;
        q_flush        = pc_src;
        q_pop          = !q_empty && id_ready && !pc_src;
        q_push         = 1'b0;
        count_after    = q_count;
        case (state)
            IDLE: begin
                if (pc_src) begin
                    fetch_pc_next = word_align(new_pc);
                end else if (!q_full) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (pc_src) begin
                    fetch_pc_next = word_align(new_pc);
                    if (imem_ack) begin
                        state_next = IDLE;
                    end else begin
                        // imem_addr must stay put until the ack, so remember it.
                        state_next     = DROP;
                        drop_addr_next = fetch_pc;
                    end
                end else if (imem_ack) begin
                    fetch_pc_next = fetch_pc + PC_INCR;
                    q_push        = !(bypass_hit && id_ready);
                    count_after   = q_count + CW'(q_push) - CW'(q_pop);
                    if (count_after >= CW'(QUEUE_DEPTH)) state_next = IDLE;
                end
            end
            DROP: begin
                if (pc_src) fetch_pc_next = word_align(new_pc);
                if (imem_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign imem_req  = (state != IDLE);
    assign imem_addr = (state == DROP) ? drop_addr : fetch_pc;

    // Decode-side view: queue head first, else the bypassed word, else zeros.
    always_comb begin
        head_instr = '0;
        head_pc    = '0;
        if (!q_empty) begin
            head_instr = q_head[63:32];
            head_pc    = q_head[31:0];
        end else if (bypass_hit) begin
            head_instr = imem_rdata;
            head_pc    = fetch_pc;
        end
    end

    assign id_valid    = !q_empty || bypass_hit;
    assign id_instr    = head_instr;
    assign id_pc       = head_pc;
    assign id_pc_plus4 = id_valid ? head_pc + PC_INCR : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; imem returns ~addr as the instruction word.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        pc_src;
    logic [31:0] new_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_rdata = ~imem_addr;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc_src      (pc_src),
        .new_pc      (new_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at posedge+1 with rst_n just released and the DUT in IDLE.
    task automatic do_reset();
        rst_n = 1'b0; imem_ack = 1'b0; pc_src = 1'b0; new_pc = '0; id_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        cyc();
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rst_first_req: got %b expected 1", imem_req); end
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_async_req: got %b expected 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr: got %h expected 0", imem_addr); end
        checks++; if ({id_valid, id_instr, id_pc, id_pc_plus4} !== '0) begin failures++; $display("FAIL rst_id: got v=%b i=%h pc=%h p4=%h expected all 0", id_valid, id_instr, id_pc, id_pc_plus4); end
        cyc();
        rst_n = 1'b1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_release_req: got %b expected 0", imem_req); end
        cyc();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL rst_enter_req: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
    endtask

    task automatic test_stream();
        int acks = 0;
        int pops = 0;
        logic [31:0] exp_a = 32'h0;
        logic [31:0] exp_p = 32'h0;
        do_reset();
        imem_ack = 1'b1; id_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (imem_req && imem_ack) begin
                checks++; if (imem_addr !== exp_a) begin failures++; $display("FAIL stream_addr: got %h expected %h", imem_addr, exp_a); end
                exp_a = exp_a + 32'd4; acks++;
            end
            if (id_valid && id_ready) begin
                checks++; if (id_pc !== exp_p || id_instr !== ~exp_p || id_pc_plus4 !== exp_p + 32'd4) begin
                    failures++; $display("FAIL stream_pop: got pc=%h i=%h p4=%h expected pc=%h i=%h p4=%h", id_pc, id_instr, id_pc_plus4, exp_p, ~exp_p, exp_p + 32'd4);
                end
                exp_p = exp_p + 32'd4; pops++;
            end
        end
        checks++; if (acks != 9) begin failures++; $display("FAIL stream_acks: got %0d expected 9", acks); end
`ifdef FETCH_BYPASS_EN
        checks++; if (pops != 9) begin failures++; $display("FAIL stream_pops: got %0d expected 9", pops); end
`else
        checks++; if (pops != 8) begin failures++; $display("FAIL stream_pops: got %0d expected 8", pops); end
`endif
    endtask

    task automatic test_backpressure();
        int acks = 0;
        int pops = 0;
        bit seen_ack = 0;
        logic [31:0] exp_a = 32'h0;
        logic [31:0] exp_p = 32'h0;
        do_reset();
        imem_ack = 1'b1; id_ready = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (imem_req && imem_ack) begin
                checks++; if (imem_addr !== exp_a) begin failures++; $display("FAIL bp_addr: got %h expected %h", imem_addr, exp_a); end
                exp_a = exp_a + 32'd4; acks++;
            end
        end
        checks++; if (acks != 2) begin failures++; $display("FAIL bp_acks: got %0d expected 2", acks); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_low: got %b expected 0", imem_req); end
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin failures++; $display("FAIL bp_head: got v=%b pc=%h expected v=1 pc=0", id_valid, id_pc); end
        cyc();
        id_ready = 1'b1;
        for (int i = 0; i < 12 && pops < 3; i++) begin
            @(negedge clk);
            if (imem_req && imem_ack && !seen_ack) begin
                seen_ack = 1;
                checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL bp_resume_addr: got %h expected 00000008", imem_addr); end
            end
            if (id_valid && id_ready) begin
                checks++; if (id_pc !== exp_p) begin failures++; $display("FAIL bp_drain: got %h expected %h", id_pc, exp_p); end
                exp_p = exp_p + 32'd4; pops++;
            end
        end
        checks++; if (pops != 3 || !seen_ack) begin failures++; $display("FAIL bp_timeout: got pops=%0d ack=%0d expected pops=3 ack=1", pops, seen_ack); end
    endtask

    task automatic test_drop();
        bit seen_ack = 0;
        bit seen_pop = 0;
        do_reset();
        imem_ack = 1'b0; id_ready = 1'b1;
        cyc();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL drop_req: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
        pc_src = 1'b1; new_pc = 32'h100;
        cyc();
        pc_src = 1'b0;
        repeat (2) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || id_valid !== 1'b0) begin
                failures++; $display("FAIL drop_hold: got req=%b addr=%h v=%b expected req=1 addr=0 v=0", imem_req, imem_addr, id_valid);
            end
            cyc();
        end
        imem_ack = 1'b1;
        cyc();
        checks++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin failures++; $display("FAIL drop_discard: got req=%b v=%b expected req=0 v=0", imem_req, id_valid); end
        for (int i = 0; i < 8 && !(seen_ack && seen_pop); i++) begin
            @(negedge clk);
            if (imem_req && imem_ack && !seen_ack) begin
                seen_ack = 1;
                checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL drop_next_addr: got %h expected 00000100", imem_addr); end
            end
            if (id_valid && id_ready && !seen_pop) begin
                seen_pop = 1;
                checks++; if (id_pc !== 32'h100 || id_instr !== 32'hFFFF_FEFF) begin failures++; $display("FAIL drop_next_pc: got pc=%h i=%h expected pc=00000100 i=fffffeff", id_pc, id_instr); end
            end
        end
        checks++; if (!(seen_ack && seen_pop)) begin failures++; $display("FAIL drop_timeout: got ack=%0d pop=%0d expected 1 1", seen_ack, seen_pop); end
    endtask

    task automatic test_redirect_ack();
        bit seen_pop = 0;
        do_reset();
        imem_ack = 1'b1; id_ready = 1'b0;
        cyc();
        cyc();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || id_valid !== 1'b1 || id_pc !== 32'h0) begin
            failures++; $display("FAIL redir_pre: got req=%b addr=%h v=%b pc=%h expected req=1 addr=4 v=1 pc=0", imem_req, imem_addr, id_valid, id_pc);
        end
        pc_src = 1'b1; new_pc = 32'h203;
        cyc();
        pc_src = 1'b0;
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL redir_flush: got v=%b req=%b expected v=0 req=0", id_valid, imem_req); end
        id_ready = 1'b1;
        cyc();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL redir_addr: got req=%b addr=%h expected req=1 addr=00000200", imem_req, imem_addr); end
        for (int i = 0; i < 4 && !seen_pop; i++) begin
            @(negedge clk);
            if (id_valid && id_ready) begin
                seen_pop = 1;
                checks++; if (id_pc !== 32'h200) begin failures++; $display("FAIL redir_pc: got %h expected 00000200", id_pc); end
            end
        end
        checks++; if (!seen_pop) begin failures++; $display("FAIL redir_timeout: got no pop expected pop"); end
    endtask

    task automatic test_wrap();
        int acks = 0;
        bit seen_pop = 0;
        do_reset();
        imem_ack = 1'b1; id_ready = 1'b1;
        cyc();
        pc_src = 1'b1; new_pc = 32'hFFFF_FFFC;
        cyc();
        pc_src = 1'b0;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL wrap_idle: got %b expected 0", imem_req); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (imem_req && imem_ack) begin
                if (acks == 1) begin
                    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next_addr: got %h expected 0", imem_addr); end
                end else if (acks == 0) begin
                    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr: got %h expected fffffffc", imem_addr); end
                end
                acks++;
            end
            if (id_valid && id_ready && !seen_pop) begin
                seen_pop = 1;
                checks++; if (id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0 || id_instr !== 32'h3) begin
                    failures++; $display("FAIL wrap_pop: got pc=%h p4=%h i=%h expected pc=fffffffc p4=0 i=3", id_pc, id_pc_plus4, id_instr);
                end
            end
        end
        checks++; if (acks < 2 || !seen_pop) begin failures++; $display("FAIL wrap_timeout: got acks=%0d pop=%0d expected >=2 1", acks, seen_pop); end
    endtask

    task automatic test_latency();
        do_reset();
        imem_ack = 1'b0; id_ready = 1'b0;
        cyc();
        imem_ack = 1'b1;
        @(negedge clk);
`ifdef FETCH_BYPASS_EN
        checks++; if (id_valid !== 1'b1 || id_instr !== 32'hFFFF_FFFF || id_pc !== 32'h0 || id_pc_plus4 !== 32'h4) begin
            failures++; $display("FAIL bypass_same_cycle: got v=%b i=%h pc=%h p4=%h expected v=1 i=ffffffff pc=0 p4=4", id_valid, id_instr, id_pc, id_pc_plus4);
        end
`else
        checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0) begin failures++; $display("FAIL latency_ack_cycle: got v=%b i=%h expected v=0 i=0", id_valid, id_instr); end
`endif
        cyc();
        imem_ack = 1'b0;
        @(negedge clk);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL latency_next_cycle: got v=%b pc=%h i=%h expected v=1 pc=0 i=ffffffff", id_valid, id_pc, id_instr);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_drop();
        test_redirect_ack();
        test_wrap();
        test_latency();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
